// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, oversampling constants and baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + OVERSAMPLE * baud / 2) / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 1-cycle tick every DIV clocks; restartI realigns the phase to zero.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clkI,
    input  logic rstI,
    input  logic restartI,
    output logic tickO
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt_q, cnt_d;

    assign tickO = cnt_q == W'(DIV - 1);

    always_comb cnt_d = (restartI || tickO) ? '0 : cnt_q + W'(1);

    always_ff @(posedge clkI) begin
        if (rstI) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (8N1) with a 1-entry valid/ready output buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parityErrO output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clkI,
    input  logic                 rstI,
    input  logic                 rxI,
    output logic [DATA_BITS-1:0] dataO,
    output logic                 validO,
    input  logic                 readyI,
    output logic                 frameErrO,
    output logic                 overrunO,
    output logic                 busyO
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parityErrO
`endif
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
`ifdef UART_RX_PARITY_EN
    localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
    localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

    if (DIV < 2) begin : g_div_chk
        $error("uart_rx: baud divisor must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_chk
        $error("uart_rx: DATA_BITS must be 5..8");
    end

    logic                 rx_m_q, rx_s_q;
    uart_rx_state_t       state_q, state_d;
    logic [3:0]           smp_q, smp_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
    logic                 armed_q, armed_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 tick, restart, mid, load;
`ifdef UART_RX_PARITY_EN
    logic                 pbad_q, pbad_d;
    logic                 perr_q, perr_d;
`endif

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clkI    (clkI),
        .rstI    (rstI),
        .restartI(restart),
        .tickO   (tick)
    );

    assign mid = tick && smp_q == 4'(MID_SAMPLE - 1);

    // armed_q blocks a new start until the line has been seen idle, which also absorbs breaks
    always_comb begin
        state_d = state_q;
        smp_d   = tick ? smp_q + 4'd1 : smp_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        armed_d = armed_q;
        restart = 1'b0;
        load    = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_d  = pbad_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                armed_d = armed_q || rx_s_q;
                if (armed_q && !rx_s_q) begin
                    state_d = START;
                    restart = 1'b1;
                    smp_d   = '0;
                    armed_d = 1'b0;
                end
            end
            START: if (mid) begin
                state_d = rx_s_q ? IDLE : DATA;
                idx_d   = '0;
            end
            DATA: if (mid) begin
                sh_d    = {rx_s_q, sh_q[DATA_BITS-1:1]};
                idx_d   = idx_q + 3'd1;
                state_d = idx_q == 3'(DATA_BITS - 1) ? AFTER_DATA : DATA;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (mid) begin
                pbad_d  = rx_s_q ^ (^sh_q);
                state_d = STOP;
            end
`endif
            STOP: if (mid) begin
                state_d = IDLE;
                ferr_d  = !rx_s_q;
`ifdef UART_RX_PARITY_EN
                perr_d  = pbad_q;
                load    = rx_s_q && !pbad_q;
`else
                load    = rx_s_q;
`endif
            end
            default: state_d = IDLE;
        endcase
        valid_d = valid_q && !readyI;
        data_d  = data_q;
        ovr_d   = 1'b0;
        if (load) begin
            ovr_d   = valid_q && !readyI;
            valid_d = 1'b1;
            data_d  = (valid_q && !readyI) ? data_q : sh_q;
        end
    end

    always_ff @(posedge clkI) begin
        if (rstI) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            smp_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            armed_q <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rx_m_q  <= rxI;
            rx_s_q  <= rx_m_q;
            state_q <= state_d;
            smp_q   <= smp_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            armed_q <= armed_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= pbad_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign dataO     = data_q;
    assign validO    = valid_q;
    assign frameErrO = ferr_q;
    assign overrunO  = ovr_q;
    assign busyO     = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
    assign parityErrO = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx at DIV = 10 (160 clocks per bit).
module tb_uart_rx;

    localparam int CLK_HZ  = 1_536_000;
    localparam int BAUD    = 9600;
    localparam int BIT     = 160;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS   = 11;
`else
    localparam int NBITS   = 10;
`endif
    localparam int EXP_LAT = NBITS * BIT - BIT / 2;

    logic       clk = 1'b0, rstI = 1'b1, rx = 1'b1, readyI = 1'b0;
    logic [7:0] dataO;
    logic       validO, frameErrO, overrunO, busyO;
`ifdef UART_RX_PARITY_EN
    logic       parityErrO;
`endif

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, rise_cyc = 0;
    int ferr_n = 0, ovr_n = 0, perr_n = 0, busy_n = 0;
    logic valid_prev = 1'b0;
    logic [7:0] exp_q[$];
    int lat, f0, o0, p0, b0;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8)) dut (
        .clkI     (clk),
        .rstI     (rstI),
        .rxI      (rx),
        .dataO    (dataO),
        .validO   (validO),
        .readyI   (readyI),
        .frameErrO(frameErrO),
        .overrunO (overrunO),
        .busyO    (busyO)
`ifdef UART_RX_PARITY_EN
        ,
        .parityErrO(parityErrO)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frameErrO) ferr_n <= ferr_n + 1;
        if (overrunO) ovr_n <= ovr_n + 1;
        if (busyO) busy_n <= busy_n + 1;
`ifdef UART_RX_PARITY_EN
        if (parityErrO) perr_n <= perr_n + 1;
`endif
        if (validO && !valid_prev) rise_cyc <= cyc;
        valid_prev <= validO;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one frame from a negedge; readyI pulses at clock rdy_at, rstI for 3 clocks from rst_at.
    task automatic send(input logic [7:0] b, input logic par, input logic stop,
                        input int rdy_at, input int rst_at);
        logic [10:0] f;
        f = {stop, par, b, 1'b0};
`ifndef UART_RX_PARITY_EN
        f = {par, stop, b, 1'b0};
`endif
        start_cyc = cyc;
        for (int k = 0; k < NBITS * BIT; k++) begin
            rx = f[k / BIT];
            if (rdy_at >= 0) readyI = (k == rdy_at);
            rstI = rst_at >= 0 && k >= rst_at && k < rst_at + 3;
            @(negedge clk);
        end
    endtask

    task automatic pop_check(input string tag);
        int t;
        t = 0;
        while (validO !== 1'b1 && t < 4 * NBITS * BIT) begin
            @(negedge clk);
            t++;
        end
        check({tag, " valid"}, validO, 1);
        check({tag, " pending"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check({tag, " data"}, dataO, exp_q.pop_front());
        readyI = 1'b1;
        @(negedge clk);
        readyI = 1'b0;
        check({tag, " drop"}, validO, 0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst valid", validO, 0);
        check("rst data", dataO, 0);
        check("rst ferr", frameErrO, 0);
        check("rst ovr", overrunO, 0);
        check("rst busy", busyO, 0);
        rstI = 1'b0;
        repeat (20) @(negedge clk);

        f0 = ferr_n; o0 = ovr_n;
        exp_q.push_back(8'hA5);
        send(8'hA5, ^8'hA5, 1'b1, -1, -1);
        lat = rise_cyc - start_cyc;
        check("A5 latency window", lat >= EXP_LAT - 10 && lat <= EXP_LAT + 10, 1);
        pop_check("A5");
        check("A5 ferr", ferr_n - f0, 0);
        check("A5 ovr", ovr_n - o0, 0);

        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        send(8'h5A, ^8'h5A, 1'b1, -1, -1);
        check("5A held", validO, 1);
        check("5A data", dataO, exp_q.pop_front());
        o0 = ovr_n;
        send(8'hC3, ^8'hC3, 1'b1, lat - 1, -1);
        check("load-wins ovr", ovr_n - o0, 0);
        pop_check("C3");

        f0 = ferr_n; o0 = ovr_n;
        exp_q.push_back(8'h3C);
        send(8'h3C, ^8'h3C, 1'b1, -1, -1);
        send(8'h81, ^8'h81, 1'b1, -1, -1);
        check("overrun once", ovr_n - o0, 1);
        pop_check("3C kept");
        check("overrun ferr", ferr_n - f0, 0);

        f0 = ferr_n; b0 = busy_n;
        rx = 1'b0;
        repeat (60) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch valid", validO, 0);
        check("glitch ferr", ferr_n - f0, 0);
        check("glitch busy idle", busyO, 0);
        check("glitch busy seen", busy_n > b0, 1);

        f0 = ferr_n;
        send(8'h55, ^8'h55, 1'b0, -1, -1);
        check("ferr once", ferr_n - f0, 1);
        check("ferr valid", validO, 0);
        repeat (20 * BIT) @(negedge clk);
        check("break ferr", ferr_n - f0, 1);
        check("break valid", validO, 0);
        check("break busy", busyO, 0);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        exp_q.push_back(8'h12);
        send(8'h12, ^8'h12, 1'b1, -1, -1);
        pop_check("12");
        check("after break ferr", ferr_n - f0, 1);

        send(8'hFF, ^8'hFF, 1'b1, -1, 5 * BIT + BIT / 2);
        repeat (20) @(negedge clk);
        check("rst frame valid", validO, 0);
        check("rst frame busy", busyO, 0);
        exp_q.push_back(8'h0F);
        send(8'h0F, ^8'h0F, 1'b1, -1, -1);
        pop_check("0F");

`ifdef UART_RX_PARITY_EN
        p0 = perr_n;
        exp_q.push_back(8'h07);
        send(8'h07, 1'b1, 1'b1, -1, -1);
        pop_check("07 par ok");
        check("07 perr none", perr_n - p0, 0);
        send(8'h07, 1'b0, 1'b1, -1, -1);
        check("07 perr once", perr_n - p0, 1);
        check("07 perr valid", validO, 0);
        f0 = ferr_n; p0 = perr_n;
        send(8'h07, 1'b0, 1'b0, -1, -1);
        check("both perr", perr_n - p0, 1);
        check("both ferr", ferr_n - f0, 1);
        check("both valid", validO, 0);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
`endif

        repeat (BIT) @(negedge clk);
        check("end valid", validO, 0);
        check("queue empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
